// File: rtl/tmr_seq_voter.sv
// Registered W-bit triple-modular-redundancy voter with per-replica fault tracking.
// Degrades TMR -> DUPLEX -> FAIL as replicas persistently disagree with the vote.
module tmr_seq_voter #(
    parameter int W         = 10,
    parameter int FAULT_THR = 4,
    parameter int CW        = 3,
    parameter int EW        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] rep_a,
    input  logic [W-1:0] rep_b,
    input  logic [W-1:0] rep_c,
    input  logic         clr_fault,
    output logic         out_valid,
    output logic [W-1:0] vote_out,
    output logic         mismatch,
    output logic [2:0]   fault,
    output logic [1:0]   mode,
    output logic [EW-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_TMR    = 2'd0,
        MODE_DUPLEX = 2'd1,
        MODE_FAIL   = 2'd2
    } mode_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_THR = CW'(FAULT_THR);
    localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

    function automatic logic [W-1:0] maj3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic mode_e mode_of(input logic [2:0] f);
        logic [1:0] pop;
        pop = {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
        case (pop)
            2'd0:    return MODE_TMR;
            2'd1:    return MODE_DUPLEX;
            default: return MODE_FAIL;
        endcase
    endfunction

    mode_e         mode_r;
    logic [2:0]    fault_r;
    logic [CW-1:0] cnt_r [3];
    logic [W-1:0]  vote_r;
    logic          mis_r;
    logic          valid_r;
    logic [EW-1:0] err_r;

    logic [W-1:0]  rep_s [3];
    logic [W-1:0]  maj_s;
    logic [W-1:0]  vote_nxt_s;
    logic          mis_nxt_s;
    logic [2:0]    dis_s;
    logic [1:0]    x_s;
    logic [1:0]    y_s;
    logic [2:0]    fault_nxt_s;
    logic [CW-1:0] cnt_nxt_s [3];
    logic [CW-1:0] inc_s;

    assign rep_s[0] = rep_a;
    assign rep_s[1] = rep_b;
    assign rep_s[2] = rep_c;
    assign maj_s    = maj3(rep_a, rep_b, rep_c);

    // Vote and per-replica disagreement for the current sample under the current mode.
    always_comb begin
        vote_nxt_s = vote_r;
        mis_nxt_s  = 1'b0;
        dis_s      = 3'b000;
        // The two surviving replicas in DUPLEX, lower index first.
        case (fault_r)
            3'b001:  begin x_s = 2'd1; y_s = 2'd2; end
            3'b010:  begin x_s = 2'd0; y_s = 2'd2; end
            default: begin x_s = 2'd0; y_s = 2'd1; end
        endcase
        case (mode_r)
            MODE_TMR: begin
                vote_nxt_s = maj_s;
                dis_s[0]   = (rep_s[0] != maj_s);
                dis_s[1]   = (rep_s[1] != maj_s);
                dis_s[2]   = (rep_s[2] != maj_s);
                mis_nxt_s  = |dis_s;
            end
            MODE_DUPLEX: begin
                if (rep_s[x_s] == rep_s[y_s]) begin
                    vote_nxt_s = rep_s[x_s];
                end else begin
                    mis_nxt_s  = 1'b1;
                    dis_s[x_s] = 1'b1;
                    dis_s[y_s] = 1'b1;
                end
            end
            default: begin
                mis_nxt_s = 1'b1;
            end
        endcase
    end

    // Next disagreement counters and sticky fault flags.
    always_comb begin
        fault_nxt_s = fault_r;
        cnt_nxt_s   = cnt_r;
        inc_s       = '0;
        if (clr_fault) begin
            fault_nxt_s = 3'b000;
            for (int k = 0; k < 3; k++) begin
                cnt_nxt_s[k] = '0;
            end
        end else if (in_valid && (mode_r != MODE_FAIL)) begin
            for (int k = 0; k < 3; k++) begin
                if (fault_r[k]) begin
                    cnt_nxt_s[k] = cnt_r[k];
                end else if (dis_s[k]) begin
                    inc_s        = (cnt_r[k] == CNT_MAX) ? cnt_r[k] : cnt_r[k] + CW'(1);
                    cnt_nxt_s[k] = inc_s;
                    if (inc_s == CNT_THR) begin
                        fault_nxt_s[k] = 1'b1;
                    end else begin
                        fault_nxt_s[k] = fault_r[k];
                    end
                end else begin
                    cnt_nxt_s[k] = '0;
                end
            end
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= MODE_TMR;
            fault_r <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                cnt_r[k] <= '0;
            end
            vote_r  <= '0;
            mis_r   <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= '0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                vote_r <= vote_nxt_s;
                mis_r  <= mis_nxt_s;
                if (mis_nxt_s && (err_r != ERR_MAX)) begin
                    err_r <= err_r + EW'(1);
                end
            end else begin
                mis_r <= 1'b0;
            end
            fault_r <= fault_nxt_s;
            cnt_r   <= cnt_nxt_s;
            mode_r  <= mode_of(fault_nxt_s);
        end
    end

    assign out_valid = valid_r;
    assign vote_out  = vote_r;
    assign mismatch  = mis_r;
    assign fault     = fault_r;
    assign mode      = mode_r;
    assign err_cnt   = err_r;

endmodule

// File: tb/tb_tmr_seq_voter.sv
// Scoreboard bench for tmr_seq_voter: a behavioural model queues expected votes per sample.
module tb_tmr_seq_voter;
    localparam int W   = 10;
    localparam int THR = 4;
    localparam int CW  = 3;
    localparam int EW  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] rep_a, rep_b, rep_c;
    logic         clr_fault;
    logic         out_valid;
    logic [W-1:0] vote_out;
    logic         mismatch;
    logic [2:0]   fault;
    logic [1:0]   mode;
    logic [EW-1:0] err_cnt;

    tmr_seq_voter #(.W(W), .FAULT_THR(THR), .CW(CW), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .rep_a(rep_a), .rep_b(rep_b), .rep_c(rep_c), .clr_fault(clr_fault),
        .out_valid(out_valid), .vote_out(vote_out), .mismatch(mismatch),
        .fault(fault), .mode(mode), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] vote;
        logic         mis;
    } exp_t;
    exp_t sb_q[$];

    logic [2:0]   m_fault;
    int           m_cnt [3];
    logic [1:0]   m_mode;
    int           m_err;
    logic [W-1:0] m_vote;
    logic         m_ovalid;

    task automatic model_reset();
        m_fault  = 3'b000;
        m_cnt    = '{0, 0, 0};
        m_mode   = 2'd0;
        m_err    = 0;
        m_vote   = '0;
        m_ovalid = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle, advance the model, queue the expected vote, land at posedge+1.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic clr);
        logic [W-1:0] r [3];
        logic [W-1:0] vote;
        logic [2:0]   d;
        logic         mis;
        int           nf, x, y;
        in_valid  = v;
        rep_a     = a;
        rep_b     = b;
        rep_c     = c;
        clr_fault = clr;
        r[0] = a; r[1] = b; r[2] = c;
        nf   = $countones(m_fault);
        d    = 3'b000;
        mis  = 1'b0;
        vote = m_vote;
        if (v) begin
            if (nf == 0) begin
                for (int i = 0; i < W; i++)
                    vote[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
                for (int k = 0; k < 3; k++) d[k] = (r[k] != vote);
                mis = (d != 3'b000);
            end else if (nf == 1) begin
                x = -1; y = -1;
                for (int k = 0; k < 3; k++)
                    if (!m_fault[k]) begin
                        if (x < 0) x = k; else y = k;
                    end
                if (r[x] == r[y]) vote = r[x];
                else begin
                    mis = 1'b1; d[x] = 1'b1; d[y] = 1'b1;
                end
            end else begin
                mis = 1'b1;
            end
            m_vote = vote;
            sb_q.push_back('{vote, mis});
            if (mis && m_err < 65535) m_err++;
        end
        if (clr) begin
            m_fault = 3'b000;
            m_cnt   = '{0, 0, 0};
        end else if (v && nf < 2) begin
            for (int k = 0; k < 3; k++)
                if (!m_fault[k]) begin
                    if (d[k]) begin
                        if (m_cnt[k] < 7) m_cnt[k]++;
                        if (m_cnt[k] == THR) m_fault[k] = 1'b1;
                    end else m_cnt[k] = 0;
                end
        end
        nf       = $countones(m_fault);
        m_mode   = (nf == 0) ? 2'd0 : (nf == 1) ? 2'd1 : 2'd2;
        m_ovalid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr_fault = 1'b0;
        rep_a = '0; rep_b = '0; rep_c = '0;
        model_reset();
        #12;
        checks++;
        if ({out_valid, vote_out, mismatch, fault, mode, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: got ov=%b vote=%h mis=%b fault=%b mode=%0d err=%0d, want all zero",
                     out_valid, vote_out, mismatch, fault, mode, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_agree();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL agree_valid: got %b want 1", out_valid);
            end
            e = sb_q.pop_front();
            checks++;
            if (vote_out !== e.vote || mismatch !== e.mis || vote_out !== 10'h155) begin
                failures++;
                $display("FAIL agree_vote: got %h/%b want %h/%b", vote_out, mismatch, e.vote, e.mis);
            end
            checks++;
            if (mode !== 2'd0 || err_cnt !== 16'd0) begin
                failures++; $display("FAIL agree_status: got mode=%0d err=%0d want 0/0", mode, err_cnt);
            end
        end
    endtask

    task automatic test_upset();
        exp_t e;
        step(1'b1, 10'h155, 10'h155, 10'h154, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (vote_out !== e.vote || mismatch !== e.mis || vote_out !== 10'h155 || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL upset_vote: got %h/%b want %h/%b", vote_out, mismatch, e.vote, e.mis);
        end
        checks++;
        if (err_cnt !== 16'd1 || fault !== 3'b000) begin
            failures++; $display("FAIL upset_status: got err=%0d fault=%b want 1/000", err_cnt, fault);
        end
        step(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
        void'(sb_q.pop_front());
    endtask

    task automatic test_intermittent();
        exp_t e;
        logic agree;
        for (int i = 0; i < 8; i++) begin
            agree = (i == 3) || (i == 7);
            step(1'b1, 10'h0AA, 10'h0AA, agree ? 10'h0AA : 10'h000, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (vote_out !== e.vote || mismatch !== e.mis) begin
                failures++;
                $display("FAIL intermit_vote[%0d]: got %h/%b want %h/%b", i, vote_out, mismatch, e.vote, e.mis);
            end
            checks++;
            if (fault !== 3'b000 || mode !== 2'd0 || err_cnt !== m_err[EW-1:0]) begin
                failures++;
                $display("FAIL intermit_status[%0d]: got fault=%b mode=%0d err=%0d want 000/0/%0d",
                         i, fault, mode, err_cnt, m_err);
            end
        end
    endtask

    task automatic test_persistent();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'h0AA, 10'h0AA, 10'h000, 1'b0);
            void'(sb_q.pop_front());
            checks++;
            if (fault !== m_fault || mode !== m_mode) begin
                failures++;
                $display("FAIL persist_step[%0d]: got fault=%b mode=%0d want %b/%0d", i, fault, mode, m_fault, m_mode);
            end
        end
        checks++;
        if (fault !== 3'b100 || mode !== 2'd1) begin
            failures++; $display("FAIL persist_final: got fault=%b mode=%0d want 100/1", fault, mode);
        end
        step(1'b1, 10'h0AA, 10'h0AB, 10'h000, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (vote_out !== e.vote || mismatch !== e.mis || vote_out !== 10'h0AA || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL duplex_split: got %h/%b want %h/%b", vote_out, mismatch, e.vote, e.mis);
        end
        step(1'b1, 10'h123, 10'h123, 10'h3FF, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (vote_out !== e.vote || mismatch !== e.mis) begin
            failures++;
            $display("FAIL duplex_agree: got %h/%b want %h/%b", vote_out, mismatch, e.vote, e.mis);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   err_before;
        step(1'b0, '0, '0, '0, 1'b1);
        checks++;
        if (mode !== 2'd0 || fault !== 3'b000 || out_valid !== 1'b0) begin
            failures++; $display("FAIL clr_idle: got mode=%0d fault=%b ov=%b want 0/000/0", mode, fault, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'h0F0, 10'h0F1, 10'h0F2, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (vote_out !== e.vote || mismatch !== e.mis || fault !== m_fault || mode !== m_mode) begin
                failures++;
                $display("FAIL simul_step[%0d]: got %h/%b f=%b m=%0d want %h/%b f=%b m=%0d", i,
                         vote_out, mismatch, fault, mode, e.vote, e.mis, m_fault, m_mode);
            end
        end
        checks++;
        if (fault !== 3'b110 || mode !== 2'd2) begin
            failures++; $display("FAIL simul_final: got fault=%b mode=%0d want 110/2", fault, mode);
        end
        step(1'b1, 10'h3FF, 10'h000, 10'h155, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (vote_out !== 10'h0F0 || mismatch !== 1'b1 || out_valid !== 1'b1 || err_cnt !== m_err[EW-1:0]) begin
            failures++;
            $display("FAIL fail_hold: got %h/%b ov=%b err=%0d want 0f0/1/1/%0d",
                     vote_out, mismatch, out_valid, err_cnt, m_err);
        end
        err_before = m_err;
        step(1'b0, '0, '0, '0, 1'b1);
        checks++;
        if (mode !== 2'd0 || fault !== 3'b000 || err_cnt !== err_before[EW-1:0]) begin
            failures++;
            $display("FAIL clr_fail: got mode=%0d fault=%b err=%0d want 0/000/%0d", mode, fault, err_cnt, err_before);
        end
    endtask

    task automatic test_clr_priority();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'h011, 10'h011, 10'h022, 1'b0);
            void'(sb_q.pop_front());
        end
        step(1'b1, 10'h011, 10'h011, 10'h022, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if (vote_out !== e.vote || mismatch !== 1'b1 || err_cnt !== m_err[EW-1:0]) begin
            failures++;
            $display("FAIL clr_sample: got %h/%b err=%0d want %h/1/%0d", vote_out, mismatch, err_cnt, e.vote, m_err);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 10'h011, 10'h011, 10'h022, 1'b0);
            void'(sb_q.pop_front());
            checks++;
            if (fault !== ((i == 3) ? 3'b100 : 3'b000)) begin
                failures++; $display("FAIL clr_recount[%0d]: got fault=%b want %b", i, fault, m_fault);
            end
        end
        step(1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_gap();
        logic [W-1:0] vote_before;
        int           err_before;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'h200, 10'h200, 10'h201, 1'b0);
            void'(sb_q.pop_front());
        end
        vote_before = vote_out;
        err_before  = m_err;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 10'h3FF, 10'h000, 10'h155, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || vote_out !== vote_before || err_cnt !== err_before[EW-1:0] || fault !== 3'b000) begin
                failures++;
                $display("FAIL gap[%0d]: got ov=%b vote=%h err=%0d fault=%b want 0/%h/%0d/000",
                         i, out_valid, vote_out, err_cnt, fault, vote_before, err_before);
            end
        end
        step(1'b1, 10'h200, 10'h200, 10'h201, 1'b0);
        void'(sb_q.pop_front());
        checks++;
        if (fault !== 3'b100 || mode !== 2'd1) begin
            failures++; $display("FAIL gap_counter_kept: got fault=%b mode=%0d want 100/1", fault, mode);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 10'h3C3, 10'h3C3, 10'h000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, vote_out, mismatch, fault, mode, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_async: got ov=%b vote=%h mis=%b fault=%b mode=%0d err=%0d want all zero",
                     out_valid, vote_out, mismatch, fault, mode, err_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 10'h3C3, 10'h3C3, 10'h3C3, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || vote_out !== 10'h000) begin
            failures++; $display("FAIL reset_release: got ov=%b vote=%h want 0/000", out_valid, vote_out);
        end
        step(1'b1, 10'h3C3, 10'h3C3, 10'h3C3, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || vote_out !== 10'h3C3 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_resume: got ov=%b vote=%h err=%0d want 1/3c3/0", out_valid, vote_out, err_cnt);
        end
        void'(sb_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_agree();
        test_upset();
        test_intermittent();
        test_persistent();
        test_simultaneous();
        test_clr_priority();
        test_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr_seq_voter.md
Name: tmr_seq_voter

Overview:
- Registered, parametrised successor to our combinational per-output majority voter for triplicated approximate logic (original, upper-approximate and lower-approximate copies).
- Votes W-bit words from three replicas and tracks per-replica disagreement over time.
- Retires a persistently faulty replica and degrades TMR -> DUPLEX -> FAIL, reporting status to the system.
- Sits between the three replica datapaths and the block output register.

Parameters:
- W, 10, width of each replica word and of the voted output.
- FAULT_THR, 4, consecutive disagreeing valid samples that mark a replica faulty (1..2^CW-1).
- CW, 3, width of each per-replica consecutive-disagreement counter.
- EW, 16, width of the total error-event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  replica words are valid this cycle.
- rep_a  in  W  replica 0 word (original copy).
- rep_b  in  W  replica 1 word.
- rep_c  in  W  replica 2 word.
- clr_fault  in  1  synchronous pulse: clears fault flags, counters and mode.
- out_valid  out  1  voted word valid.
- vote_out  out  W  voted word.
- mismatch  out  1  the sample producing vote_out had at least one disagreeing active replica.
- fault  out  3  sticky per-replica fault flags; bit0 = rep_a.
- mode  out  2  0 = TMR, 1 = DUPLEX, 2 = FAIL; 3 is never driven.
- err_cnt  out  EW  saturating count of valid samples with mismatch = 1.

Behaviour:
- Reset (rst_n = 0, asynchronous): out_valid = 0, vote_out = 0, mismatch = 0, fault = 0, mode = TMR, err_cnt = 0, all disagreement counters = 0.
- Latency: one cycle. A sample accepted at edge N drives out_valid / vote_out / mismatch after edge N.
- in_valid = 0: out_valid = 0 next cycle. vote_out holds its last value. Counters and flags do not change.
- TMR mode:
  - maj = bitwise majority (a&b | a&c | b&c).
  - vote_out <= maj.
  - Replica k disagrees when rep_k != maj (whole word).
  - mismatch = OR of the three disagreements.
- DUPLEX mode (exactly one fault bit set): the two good replicas are X (lower index) and Y.
  - X == Y: vote_out <= X, mismatch = 0.
  - X != Y: vote_out holds its previous value, mismatch = 1, and both X and Y count as disagreeing.
- FAIL mode (two or more fault bits set):
  - vote_out holds; mismatch = 1 on every valid sample.
  - out_valid still follows in_valid.
  - Counters are frozen.
- Per-replica counter, non-faulty replicas only, on valid samples:
  - Disagree: increment, saturating at 2^CW-1.
  - Agree: reset to 0.
  - When the next value reaches FAULT_THR, set that fault bit in the same edge. A faulty replica's counter holds.
- Mode transitions are evaluated from the updated fault vector at the same edge: popcount 0 -> TMR, 1 -> DUPLEX, 2 or 3 -> FAIL.
  - Two replicas reaching threshold on the same edge go directly TMR -> FAIL.
  - No transition ever leaves FAIL except clr_fault or reset.
- err_cnt increments on every valid sample with mismatch = 1 and saturates at 2^EW-1. It is cleared only by reset.
- clr_fault has priority over in_valid:
  - The same-cycle sample is still voted with the pre-clear mode, and out_valid/vote_out update normally.
  - fault, mode and the disagreement counters go to their reset values.
  - That sample's disagreement is not counted; err_cnt still counts it.
- Asserting rst_n mid-stream discards any in-flight sample; out_valid = 0 the cycle after release until the next in_valid.

Test Plan:
- Reset, then a = b = c = 0x155 valid for 3 cycles -> out_valid = 1 one cycle after each, vote_out = 0x155, mismatch = 0, mode = 0, err_cnt = 0.
- TMR single-bit upset: a = 0x155, b = 0x155, c = 0x154 for 1 cycle -> vote_out = 0x155, mismatch = 1, err_cnt = 1, fault = 000.
- Persistent fault, FAULT_THR = 4: c = 0x000 while a = b = 0x0AA for 4 valid cycles -> fault = 100 and mode = 1 after the 4th edge.
  - Then a = 0x0AA, b = 0x0AB -> vote_out holds 0x0AA, mismatch = 1.
- Intermittent disagreement: c disagrees 3 times, agrees once, disagrees 3 times -> fault stays 000, mode stays 0.
- Simultaneous threshold: b and c each differ from a and from each other so that maj = a, for 4 cycles -> fault = 110, mode = 2 on the same edge; vote_out holds thereafter.
  - clr_fault pulse -> mode = 0, fault = 000, err_cnt unchanged.
- Gap and reset: in_valid low for 5 cycles -> out_valid = 0, counters unchanged.
  - rst_n pulsed low mid-operation (asynchronous, between edges) -> all outputs zero immediately.
